// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: reset PC, instruction width, queue entry, fetch FSM states.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam int          ILEN         = 32;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [31:0]     pc;
  } qent_t;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fstate_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous power-of-two FIFO with push/pop/flush and occupancy count.
// Head entry is read straight out of the storage registers, so dout is
// registered data valid the cycle after the push that wrote it.
// Push on a full queue is legal only together with a pop.
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  T                         din,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Pointer/count update; flush discards everything but leaves storage as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word fetches, queues returned words
// for decode, and handles redirects by flushing the queue and dropping the
// responses of every request still in flight.
// Optional statistics counters are built when FETCH_STATS_EN is defined.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [ILEN-1:0]  imem_rsp_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [ILEN-1:0]  instr,
  output logic [31:0]      instr_pc,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             halt,
  output logic [CNT_W-1:0] instruction_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  fstate_t     state;
  logic [31:0] pc;
  logic [AW:0] drop;

  logic        xfer;
  logic        iq_push, iq_pop, iq_full, iq_empty;
  logic        tq_push, tq_pop, tq_full, tq_empty;
  logic [AW:0] iq_cnt, tq_cnt, tq_cnt_nxt;
  logic [AW+1:0] occ;
  qent_t       iq_din, iq_dout;
  logic [31:0] tq_dout;
  logic        unused_low;

  // Low redirect bits are forced to zero; keep them visibly consumed.
  assign unused_low = ^redirect_pc[1:0];

  // The tag queue occupancy is the outstanding-request count.
  assign occ            = (AW+2)'(iq_cnt) + (AW+2)'(tq_cnt);
  assign imem_req_valid = (state == RUN) && (occ < (AW+2)'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign xfer           = imem_req_valid & imem_req_ready;

  assign tq_push    = xfer & ~tq_full;
  assign tq_pop     = imem_rsp_valid & ~tq_empty;
  assign tq_cnt_nxt = tq_cnt + (AW+1)'(tq_push) - (AW+1)'(tq_pop);

  // Redirect kills the head pop and any response landing in the same cycle.
  assign iq_pop  = instr_valid & instr_ready & ~redirect_valid;
  assign iq_push = imem_rsp_valid & (drop == '0) & ~redirect_valid & (~iq_full | iq_pop);
  assign iq_din  = '{instr: imem_rsp_data, pc: tq_dout};

  assign instr_valid = ~iq_empty;
  assign instr       = iq_dout.instr;
  assign instr_pc    = iq_dout.pc;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(qent_t)) u_iq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (iq_push),
    .pop   (iq_pop),
    .flush (redirect_valid),
    .din   (iq_din),
    .dout  (iq_dout),
    .full  (iq_full),
    .empty (iq_empty),
    .count (iq_cnt)
  );

  // Tag queue is never flushed: stale responses still retire their tag.
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(logic [31:0])) u_tq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tq_push),
    .pop   (tq_pop),
    .flush (1'b0),
    .din   (pc),
    .dout  (tq_dout),
    .full  (tq_full),
    .empty (tq_empty),
    .count (tq_cnt)
  );

  // Fetch FSM: one idle boot cycle, then run/halt follows the halt level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else begin
      unique case (state)
        BOOT:    state <= halt ? HALTED : RUN;
        RUN:     if (halt)  state <= HALTED;
        HALTED:  if (!halt) state <= RUN;
        default: state <= BOOT;
      endcase
    end
  end

  // PC: redirect wins over the post-transfer increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pc <= RESET_PC;
    else if (redirect_valid) pc <= {redirect_pc[31:2], 2'b00};
    else if (xfer)           pc <= pc + 32'd4;
  end

  // Drop count: on redirect every request left in flight becomes stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 drop <= '0;
    else if (redirect_valid)                    drop <= tq_cnt_nxt;
    else if (imem_rsp_valid && (drop != '0))    drop <= drop - 1'b1;
  end

`ifdef FETCH_STATS_EN
  // Saturating delivery and stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction_count <= '0;
      stall_count       <= '0;
    end else begin
      if (iq_pop && (instruction_count != '1))
        instruction_count <= instruction_count + 1'b1;
      if ((state != HALTED) && !instr_valid && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end
`else
  assign instruction_count = '0;
  assign stall_count       = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// phase, checked against a stream-level reference (expected fetch and
// delivery address sequences) and a latency-randomized memory model.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic [31:0] instruction_count, stall_count;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .imem_req_valid    (imem_req_valid),
    .imem_req_ready    (imem_req_ready),
    .imem_req_addr     (imem_req_addr),
    .imem_rsp_valid    (imem_rsp_valid),
    .imem_rsp_data     (imem_rsp_data),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .instr             (instr),
    .instr_pc          (instr_pc),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .halt              (halt),
    .instruction_count (instruction_count),
    .stall_count       (stall_count)
  );

  int nchk = 0, nfail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];

  int          cyc, last_due, lat_lo = 1, lat_hi = 1;
  int          pops, stalls, xfers;
  logic [31:0] exp_req, exp_pc, prev_addr;
  logic        prev_halt, prev_redir, prev_stall_req;

  // One clock cycle: memory answers, inputs driven, reference updated.
  task automatic step(input logic rr, input logic ir, input logic rv,
                      input logic [31:0] rp, input logic h);
    logic rsp, xfer, pop;
    logic [31:0] rdata;
    pend_t p;
    int due;
    rsp = 1'b0; rdata = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      rsp = 1'b1; rdata = memword(p.addr);
    end
    imem_req_ready = rr; instr_ready = ir; redirect_valid = rv;
    redirect_pc = rp; halt = h; imem_rsp_valid = rsp; imem_rsp_data = rdata;
    if (prev_halt)  chk("halt_no_req", imem_req_valid, 0);
    if (prev_redir) chk("redir_empty", instr_valid, 0);
    if (prev_stall_req && imem_req_valid) chk("addr_stable", imem_req_addr, prev_addr);
    xfer = imem_req_valid & rr;
    if (xfer) begin
      chk("req_addr", imem_req_addr, exp_req);
      exp_req += 32'd4; xfers++;
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{imem_req_addr, due});
      chk("outstanding_le_depth", pend.size() <= DEPTH, 1);
    end
    pop = instr_valid & ir & ~rv;
    if (pop) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr", instr, memword(exp_pc));
      exp_pc += 32'd4; pops++;
    end
    if (!(cyc > 0 && prev_halt) && !instr_valid) stalls++;
    if (rv) begin
      exp_req = {rp[31:2], 2'b00};
      exp_pc  = {rp[31:2], 2'b00};
    end
    prev_halt = h; prev_redir = rv;
    prev_stall_req = imem_req_valid & ~rr & ~rv;
    prev_addr = imem_req_addr;
    @(posedge clk); #1; cyc++;
  endtask

  task automatic check_counters(input string tag);
`ifdef FETCH_STATS_EN
    chk({tag, "_icount"}, instruction_count, pops);
    chk({tag, "_scount"}, stall_count, stalls);
`else
    chk({tag, "_icount"}, instruction_count, 0);
    chk({tag, "_scount"}, stall_count, 0);
`endif
  endtask

  // Reset DUT and memory model together, checking the reset-state outputs.
  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 0; instr_ready = 0; redirect_valid = 0; redirect_pc = '0;
    halt = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    pend.delete();
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, RPC);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_icount", instruction_count, 0);
    chk("rst_scount", stall_count, 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    cyc = 0; last_due = -1; exp_req = RPC; exp_pc = RPC;
    pops = 0; stalls = 0; xfers = 0;
    prev_halt = 0; prev_redir = 0; prev_stall_req = 0; prev_addr = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic h;
    logic [31:0] rp;
    @(posedge clk); #1;
    do_reset();

    // Boot, first fetch, then backpressure from decode.
    chk("boot_no_req", imem_req_valid, 0);
    step(1, 0, 0, '0, 0);
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, RPC);
    repeat (11) step(1, 0, 0, '0, 0);
    chk("bp_xfers", xfers, DEPTH);
    chk("bp_req_stopped", imem_req_valid, 0);
    check_counters("bp");
    repeat (10) step(1, 1, 0, '0, 0);
    chk("pops_ge3", pops >= 3, 1);
    check_counters("run");

    // Redirect with two requests in flight at latency 3.
    lat_lo = 3; lat_hi = 3;
    for (int k = 0; k < 40 && pend.size() != 2; k++) step(1, 1, 0, '0, 0);
    chk("two_outstanding", pend.size(), 2);
    step(1, 1, 1, 32'h0040_0043, 0);
    repeat (15) step(1, 1, 0, '0, 0);

    // Memory-side ready toggling every cycle.
    lat_lo = 1;
    for (int i = 0; i < 20; i++) step(i[0], 1, 0, '0, 0);

    // Halt with exactly one response in flight.
    lat_lo = 3; lat_hi = 3;
    for (int k = 0; k < 40 && pend.size() != 1; k++) step(0, 1, 0, '0, 0);
    chk("one_outstanding", pend.size(), 1);
    step(0, 0, 0, '0, 1);
    repeat (7) step(1, 0, 0, '0, 1);
    chk("halt_rsp_enqueued", instr_valid, 1);
    check_counters("halt");
    repeat (10) step(1, 1, 0, '0, 0);

    // Redirect with decode ready on a full queue.
    lat_lo = 1; lat_hi = 1;
    repeat (8) step(1, 0, 0, '0, 0);
    chk("full_req_stopped", imem_req_valid, 0);
    chk("full_instr_valid", instr_valid, 1);
    check_counters("pre_flush");
    step(1, 1, 1, 32'h0040_0100, 0);
    check_counters("post_flush");
    repeat (10) step(1, 1, 0, '0, 0);

    // Randomized traffic: latency, readies, halts, redirects (incl. PC wrap).
    lat_lo = 1; lat_hi = 4; h = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) h = ~h;
      rp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : RPC + ($urandom_range(0, 1023) << 2);
      rp = rp ^ 32'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 15) == 0, rp, h);
    end
    repeat (20) step(1, 1, 0, '0, 0);
    check_counters("rand");
    chk("rand_progress", pops > 100, 1);

    // Reset in the middle of traffic.
    repeat (3) step(1, 1, 0, '0, 0);
    do_reset();
    lat_lo = 2; lat_hi = 2;
    repeat (12) step(1, 1, 0, '0, 0);
    chk("post_reset_progress", pops > 0, 1);
    check_counters("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
